tia_audio_channel: RTL and testbench

- Single Atari 2600 TIA-style audio channel, clocked at the audio rate (~30 kHz).
- A 20-bit control word supplies the channel's control (AUDC), frequency (AUDF) and volume (AUDV) fields.
- A frequency divider generates waveform ticks; on each tick a 9-bit waveform shift register advances in the mode selected by AUDC.
- The register's bit 0 is the waveform bit; it gates the volume to the 4-bit audio output.

---
 rtl/tia_audio_channel.sv | 141 ++++++++++++++
 tb/tb_tia_audio_channel.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tia_audio_channel.sv
//==============================================================================
// Module   : tia_audio_channel
// Purpose  : One TIA-style audio channel. A 5-bit frequency divider produces
//            waveform ticks; each tick advances a 9-bit waveform register in
//            the mode chosen by AUDC. Bit 0 of that register gates AUDV onto
//            the 4-bit audio output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tia_audio_channel (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] opcode,
    output logic [8:0]  shiftReg,
    output logic [3:0]  audio_out
);

    // Waveform families decoded from AUDC
    localparam logic [2:0] c_KIND_SIL  = 3'd0;
    localparam logic [2:0] c_KIND_P4   = 3'd1;
    localparam logic [2:0] c_KIND_P5   = 3'd2;
    localparam logic [2:0] c_KIND_P9   = 3'd3;
    localparam logic [2:0] c_KIND_TONE = 3'd4;

    logic [3:0] w_audc;
    logic [4:0] w_audf;
    logic [3:0] w_audv;
    logic       w_unused_rsvd;

    logic [4:0] r_fcnt;
    logic [4:0] r_tcnt;
    logic [8:0] r_sr;

    logic       w_tick;
    logic [2:0] w_kind;
    logic [4:0] w_tlim;      // tone divisor minus one
    logic [8:0] w_sr_nxt;
    logic [4:0] w_tcnt_nxt;

    assign w_audc        = opcode[3:0];
    assign w_audf        = opcode[8:4];
    assign w_audv        = opcode[12:9];
    assign w_unused_rsvd = ^opcode[19:13];

    // Compare with >= so a lowered AUDF immediately forces a tick
    assign w_tick = (r_fcnt >= w_audf);

    // Decode AUDC into waveform family and tone divisor
    always_comb begin
        w_kind = c_KIND_SIL;
        w_tlim = 5'd0;
        case (w_audc)
            4'd0, 4'd11:                    w_kind = c_KIND_SIL;
            4'd1:                           w_kind = c_KIND_P4;
            4'd2, 4'd3, 4'd7, 4'd9, 4'd15:  w_kind = c_KIND_P5;
            4'd8:                           w_kind = c_KIND_P9;
            4'd4, 4'd5: begin
                w_kind = c_KIND_TONE;
                w_tlim = 5'd0;
            end
            4'd12, 4'd13: begin
                w_kind = c_KIND_TONE;
                w_tlim = 5'd2;
            end
            4'd6, 4'd10: begin
                w_kind = c_KIND_TONE;
                w_tlim = 5'd14;
            end
            4'd14: begin
                w_kind = c_KIND_TONE;
                w_tlim = 5'd30;
            end
            default:                        w_kind = c_KIND_SIL;
        endcase
    end

    // Next waveform/tone-counter state, applied only on a tick
    always_comb begin
        w_sr_nxt   = r_sr;
        w_tcnt_nxt = r_tcnt;
        case (w_kind)
            c_KIND_SIL: begin
                w_sr_nxt = 9'h1FF;
            end
            c_KIND_P4: begin
                // An all-zero field would lock up the LFSR; reseed it instead
                if (r_sr[3:0] == 4'h0)
                    w_sr_nxt[3:0] = 4'hF;
                else
                    w_sr_nxt[3:0] = {r_sr[0] ^ r_sr[1], r_sr[3:1]};
            end
            c_KIND_P5: begin
                if (r_sr[4:0] == 5'h00)
                    w_sr_nxt[4:0] = 5'h1F;
                else
                    w_sr_nxt[4:0] = {r_sr[0] ^ r_sr[2], r_sr[4:1]};
            end
            c_KIND_P9: begin
                if (r_sr == 9'h000)
                    w_sr_nxt = 9'h1FF;
                else
                    w_sr_nxt = {r_sr[0] ^ r_sr[4], r_sr[8:1]};
            end
            c_KIND_TONE: begin
                if (r_tcnt >= w_tlim) begin
                    w_tcnt_nxt  = 5'd0;
                    w_sr_nxt[0] = ~r_sr[0];
                end else begin
                    w_tcnt_nxt = r_tcnt + 5'd1;
                end
            end
            default: begin
                w_sr_nxt = 9'h1FF;
            end
        endcase
    end

    // Divider, tone counter and waveform register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= 5'd0;
            r_tcnt <= 5'd0;
            r_sr   <= 9'h1FF;
        end else begin
            if (w_tick) begin
                r_fcnt <= 5'd0;
                r_sr   <= w_sr_nxt;
                r_tcnt <= w_tcnt_nxt;
            end else begin
                r_fcnt <= r_fcnt + 5'd1;
            end
        end
    end

    assign shiftReg  = r_sr;
    assign audio_out = r_sr[0] ? w_audv : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_tia_audio_channel.sv
//==============================================================================
// Module   : tb_tia_audio_channel
// Purpose  : Self-checking bench for tia_audio_channel: directed sequences
//            plus randomized opcodes against a behavioural channel model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tia_audio_channel;

    logic        clk;
    logic        rst;
    logic [19:0] opcode;
    logic [8:0]  shiftReg;
    logic [3:0]  audio_out;

    int n_checks;
    int n_fail;

    // Model state
    int m_sr;
    int m_f;
    int m_t;

    tia_audio_channel u_dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .shiftReg  (shiftReg),
        .audio_out (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk_op(input int audc, input int audf, input int audv, input int rsvd);
        logic [19:0] o;
        o = 20'd0;
        o[3:0]   = audc[3:0];
        o[8:4]   = audf[4:0];
        o[12:9]  = audv[3:0];
        o[19:13] = rsvd[6:0];
        return o;
    endfunction

    // Advance an n-bit Fibonacci LFSR field held in the low bits of sr
    function automatic int poly(input int sr, input int n, input int tap);
        int mask, field, fb;
        mask  = (1 << n) - 1;
        field = sr & mask;
        if (field == 0) begin
            field = mask;
        end else begin
            fb    = (field ^ (field >> tap)) & 1;
            field = (field >> 1) | (fb << (n - 1));
        end
        return (sr & ~mask & 511) | field;
    endfunction

    // Behavioural model of one clock
    task automatic model_clock(input logic r, input logic [19:0] op);
        int audc, audf, d;
        audc = int'(op[3:0]);
        audf = int'(op[8:4]);
        if (r) begin
            m_sr = 511; m_f = 0; m_t = 0;
            return;
        end
        if (m_f < audf) begin
            m_f = m_f + 1;
            return;
        end
        m_f = 0;
        d = 0;
        case (audc)
            1:              m_sr = poly(m_sr, 4, 1);
            2, 3, 7, 9, 15: m_sr = poly(m_sr, 5, 2);
            8:              m_sr = poly(m_sr, 9, 4);
            4, 5:           d = 1;
            12, 13:         d = 3;
            6, 10:          d = 15;
            14:             d = 31;
            default:        m_sr = 511;
        endcase
        if (d != 0) begin
            if (m_t + 1 >= d) begin
                m_t  = 0;
                m_sr = m_sr ^ 1;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    // Drive one clock, update model, compare outputs after the edge
    task automatic step(input logic r, input logic [19:0] op);
        int exp_aud;
        rst    = r;
        opcode = op;
        @(posedge clk);
        model_clock(r, op);
        #1;
        exp_aud = ((m_sr & 1) != 0) ? int'(op[12:9]) : 0;
        chk("model_sr", int'(shiftReg), m_sr);
        chk("model_audio", int'(audio_out), exp_aud);
    endtask

    int exp9 [6];
    int seed_nib;
    logic [19:0] op;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_sr = 511; m_f = 0; m_t = 0;
        rst    = 1'b1;
        opcode = 20'd0;

        // Reset with AUDV=9
        op = mk_op(3, 7, 9, 0);
        step(1'b1, op);
        step(1'b1, op);
        chk("reset_sr", int'(shiftReg), 'h1FF);
        chk("reset_audio", int'(audio_out), 9);

        // 9-bit poly from reset
        exp9[0] = 'h0FF; exp9[1] = 'h07F; exp9[2] = 'h03F;
        exp9[3] = 'h01F; exp9[4] = 'h00F; exp9[5] = 'h107;
        op = mk_op(8, 0, 5, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, op);
            chk("poly9_seq", int'(shiftReg), exp9[i]);
        end
        for (int i = 6; i < 511; i++) step(1'b0, op);
        chk("poly9_period", int'(shiftReg), 'h1FF);

        // 4-bit poly from reset
        op = mk_op(1, 0, 7, 0);
        step(1'b1, op);
        step(1'b0, op); chk("poly4_1", int'(shiftReg), 'h1F7);
        step(1'b0, op); chk("poly4_2", int'(shiftReg), 'h1F3);
        step(1'b0, op); chk("poly4_3", int'(shiftReg), 'h1F1);
        step(1'b0, op); chk("poly4_4", int'(shiftReg), 'h1F8);
        seed_nib = int'(shiftReg[3:0]);
        for (int i = 0; i < 15; i++) step(1'b0, op);
        chk("poly4_period", int'(shiftReg[3:0]), seed_nib);
        chk("poly4_upper", int'(shiftReg[8:4]), 'h1F);

        // Tone, D=1, AUDF=2
        op = mk_op(4, 2, 11, 0);
        step(1'b1, op);
        step(1'b0, op); chk("tone_c1", int'(shiftReg), 'h1FF);
        step(1'b0, op); chk("tone_c2", int'(shiftReg), 'h1FF);
        step(1'b0, op); chk("tone_c3", int'(shiftReg), 'h1FE);
        chk("tone_aud_lo", int'(audio_out), 0);
        step(1'b0, op);
        step(1'b0, op);
        step(1'b0, op); chk("tone_c6", int'(shiftReg), 'h1FF);
        chk("tone_aud_hi", int'(audio_out), 11);

        // Silence with reserved bits set
        op = mk_op(0, int'($urandom_range(0, 31)), 6, 'h7F);
        step(1'b1, op);
        for (int i = 0; i < 40; i++) step(1'b0, op);
        chk("silence_sr", int'(shiftReg), 'h1FF);
        chk("silence_audio", int'(audio_out), 6);

        // AUDF lowered below the running count
        op = mk_op(8, 20, 3, 0);
        step(1'b1, op);
        for (int i = 0; i < 10; i++) step(1'b0, op);
        chk("audf_hold", int'(shiftReg), 'h1FF);
        op = mk_op(8, 3, 3, 0);
        step(1'b0, op); chk("audf_drop_tick", int'(shiftReg), 'h0FF);
        step(1'b0, op); step(1'b0, op); step(1'b0, op);
        chk("audf_wait", int'(shiftReg), 'h0FF);
        step(1'b0, op); chk("audf_next_tick", int'(shiftReg), 'h07F);
        step(1'b1, op); chk("midrun_rst", int'(shiftReg), 'h1FF);

        // Randomized opcodes and occasional resets
        op = mk_op(int'($urandom_range(0, 15)), 0, int'($urandom_range(0, 15)), 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                op = mk_op(int'($urandom_range(0, 15)),
                           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                                       : int'($urandom_range(0, 31)),
                           int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 127)));
            end
            step(($urandom_range(0, 199) == 0), op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
